// File: rtl/sdu_run_ctrl.sv
// Run-control and breakpoint unit for one CPU core on the serial debug path.
// Replaces free-running CPU clocking with a clock enable, executes host
// commands (halt, run, N-step, breakpoint set/clear) and stops the CPU when
// the PC of the instruction about to execute matches an enabled breakpoint.
//
// Ports:
//   clk_i, rst_i           single clock, synchronous active-high reset
//   cmd_valid_i/ready_o    host command handshake (ready is low only in reset)
//   cmd_op_i               0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP,
//                          6 CLR_ALL, 7 reserved (NOP)
//   cmd_idx_i/addr_i/cnt_i breakpoint index, breakpoint address, step count
//   pc_chk_i               PC of the instruction about to execute
//   cpu_ce_o               combinational CPU clock enable
//   debug_o                registered, 1 while halted (selects clk_ld)
//   halt_cause_o           0 reset, 1 host HALT, 2 breakpoint, 3 step done
//   hit_idx_o              index of the last breakpoint hit
//   steps_left_o           remaining steps in STEP mode
//   ev_halt_o              one-cycle pulse on entry to halt
//   ce_count_o             free-running count of issued clock enables
module sdu_run_ctrl #(
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [IDX_W-1:0]  cmd_idx_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [CNT_W-1:0]  cmd_cnt_i,
    input  logic [ADDR_W-1:0] pc_chk_i,
    output logic              cpu_ce_o,
    output logic              debug_o,
    output logic [1:0]        halt_cause_o,
    output logic [IDX_W-1:0]  hit_idx_o,
    output logic [CNT_W-1:0]  steps_left_o,
    output logic              ev_halt_o,
    output logic [31:0]       ce_count_o
);

    typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

    localparam logic [2:0] OpHalt   = 3'd1;
    localparam logic [2:0] OpRun    = 3'd2;
    localparam logic [2:0] OpStep   = 3'd3;
    localparam logic [2:0] OpSetBp  = 3'd4;
    localparam logic [2:0] OpClrBp  = 3'd5;
    localparam logic [2:0] OpClrAll = 3'd6;

    localparam logic [1:0] CauseHost = 2'd1;
    localparam logic [1:0] CauseBp   = 2'd2;
    localparam logic [1:0] CauseStep = 2'd3;

    state_e              state_q, state_d;
    logic [NUM_BP-1:0]   bp_en_q, bp_en_d;
    logic [ADDR_W-1:0]   bp_addr_q [NUM_BP];
    logic [ADDR_W-1:0]   bp_addr_d [NUM_BP];
    logic                skip_bp_q, skip_bp_d;
    logic                debug_q, debug_d;
    logic [1:0]          cause_q, cause_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]    steps_q, steps_d;
    logic                ev_halt_q, ev_halt_d;
    logic [31:0]         ce_cnt_q, ce_cnt_d;

    logic                cmd_acc;
    logic                halt_acc;
    logic                hit;
    logic [IDX_W-1:0]    hit_sel;
    logic                bp_stop;
    logic                ce;

    assign cmd_ready_o = ~rst_i;
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign halt_acc    = cmd_acc && (cmd_op_i == OpHalt);

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc_chk_i)) begin
                hit     = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    // skip_bp lets the CPU resume from the PC it was stopped on.
    assign bp_stop = hit & ~skip_bp_q;
    assign ce      = (state_q != StHalt) & ~bp_stop & ~halt_acc;

    always_comb begin
        state_d   = state_q;
        skip_bp_d = skip_bp_q;
        cause_d   = cause_q;
        hit_idx_d = hit_idx_q;
        steps_d   = steps_q;

        if (ce) begin
            skip_bp_d = 1'b0;
        end

        case (state_q)
            StHalt: begin
                if (cmd_acc && (cmd_op_i == OpRun)) begin
                    state_d   = StRun;
                    skip_bp_d = 1'b1;
                end else if (cmd_acc && (cmd_op_i == OpStep)) begin
                    state_d   = StStep;
                    skip_bp_d = 1'b1;
                    steps_d   = (cmd_cnt_i == '0) ? CNT_W'(1) : cmd_cnt_i;
                end
            end
            StRun, StStep: begin
                // Priority: host HALT, then breakpoint, then step exhaustion.
                if (halt_acc) begin
                    state_d = StHalt;
                    cause_d = CauseHost;
                end else if (bp_stop) begin
                    state_d   = StHalt;
                    cause_d   = CauseBp;
                    hit_idx_d = hit_sel;
                end else if ((state_q == StStep) && ce) begin
                    steps_d = steps_q - CNT_W'(1);
                    if (steps_q == CNT_W'(1)) begin
                        state_d = StHalt;
                        cause_d = CauseStep;
                    end
                end
            end
            default: state_d = StHalt;
        endcase

        ev_halt_d = (state_q != StHalt) && (state_d == StHalt);
        debug_d   = (state_d == StHalt);
        ce_cnt_d  = ce_cnt_q + 32'(ce);
    end

    // Breakpoint register file; an index with no matching slot changes nothing.
    always_comb begin
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        if (cmd_acc) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                if (32'(cmd_idx_i) == 32'(i)) begin
                    if (cmd_op_i == OpSetBp) begin
                        bp_en_d[i]   = 1'b1;
                        bp_addr_d[i] = cmd_addr_i;
                    end else if (cmd_op_i == OpClrBp) begin
                        bp_en_d[i] = 1'b0;
                    end
                end
            end
            if (cmd_op_i == OpClrAll) begin
                bp_en_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StHalt;
            bp_en_q   <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) begin
                bp_addr_q[i] <= '0;
            end
            skip_bp_q <= 1'b0;
            debug_q   <= 1'b1;
            cause_q   <= 2'd0;
            hit_idx_q <= '0;
            steps_q   <= '0;
            ev_halt_q <= 1'b0;
            ce_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
            skip_bp_q <= skip_bp_d;
            debug_q   <= debug_d;
            cause_q   <= cause_d;
            hit_idx_q <= hit_idx_d;
            steps_q   <= steps_d;
            ev_halt_q <= ev_halt_d;
            ce_cnt_q  <= ce_cnt_d;
        end
    end

    assign cpu_ce_o     = ce;
    assign debug_o      = debug_q;
    assign halt_cause_o = cause_q;
    assign hit_idx_o    = hit_idx_q;
    assign steps_left_o = steps_q;
    assign ev_halt_o    = ev_halt_q;
    assign ce_count_o   = ce_cnt_q;

endmodule

// File: tb/tb_sdu_run_ctrl.sv
// Scoreboard bench for sdu_run_ctrl: stimulus pushes the reference model's
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_sdu_run_ctrl;

    localparam int NB = 4;

    localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RUN = 3'd2, STEP = 3'd3;
    localparam logic [2:0] SETBP = 3'd4, CLRBP = 3'd5, CLRALL = 3'd6;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_idx;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_cnt;
    logic [31:0] pc_chk;
    logic        cpu_ce;
    logic        debug;
    logic [1:0]  halt_cause;
    logic [1:0]  hit_idx;
    logic [15:0] steps_left;
    logic        ev_halt;
    logic [31:0] ce_count;

    sdu_run_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_idx_i    (cmd_idx),
        .cmd_addr_i   (cmd_addr),
        .cmd_cnt_i    (cmd_cnt),
        .pc_chk_i     (pc_chk),
        .cpu_ce_o     (cpu_ce),
        .debug_o      (debug),
        .halt_cause_o (halt_cause),
        .hit_idx_o    (hit_idx),
        .steps_left_o (steps_left),
        .ev_halt_o    (ev_halt),
        .ce_count_o   (ce_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        ce;
        logic        dbg;
        logic [1:0]  cause;
        logic [1:0]  hidx;
        logic [15:0] steps;
        logic        ev;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // Reference model: plain description of the machine's observable behaviour.
    // m_mode: 0 halted, 1 running, 2 stepping.
    int          m_mode;
    bit          m_en [NB];
    logic [31:0] m_addr [NB];
    bit          m_skip;
    int          m_steps;
    int          m_cause;
    int          m_hit;
    logic [31:0] m_cnt;
    bit          m_ev;

    task automatic model_reset();
        m_mode = 0; m_skip = 0; m_steps = 0; m_cause = 0; m_hit = 0;
        m_cnt = '0; m_ev = 0;
        for (int i = 0; i < NB; i++) begin
            m_en[i] = 0;
            m_addr[i] = '0;
        end
    endtask

    task automatic model_cycle(input bit r, input bit v, input logic [2:0] op,
                               input int idx, input logic [31:0] addr, input int cnt,
                               input logic [31:0] pc);
        exp_t e;
        bit   acc, hit, ce, stop;
        int   first;
        acc = !r && v;
        hit = 0;
        first = 0;
        for (int i = 0; i < NB; i++) begin
            if (!hit && m_en[i] && m_addr[i] == pc) begin
                hit = 1;
                first = i;
            end
        end
        stop = hit && !m_skip;
        ce = (m_mode != 0) && !stop && !(acc && op == HALT);

        e.rdy = !r; e.ce = ce; e.dbg = (m_mode == 0); e.cause = 2'(m_cause);
        e.hidx = 2'(m_hit); e.steps = 16'(m_steps); e.ev = m_ev; e.cnt = m_cnt;
        sb.push_back(e);

        if (r) begin
            model_reset();
            return;
        end
        m_ev = 0;
        if (ce) begin
            m_cnt = m_cnt + 1;
            m_skip = 0;
        end
        if (m_mode == 0) begin
            if (acc && op == RUN) begin
                m_mode = 1; m_skip = 1;
            end else if (acc && op == STEP) begin
                m_mode = 2; m_skip = 1; m_steps = (cnt == 0) ? 1 : cnt;
            end
        end else begin
            if (acc && op == HALT) begin
                m_mode = 0; m_cause = 1; m_ev = 1;
            end else if (stop) begin
                m_mode = 0; m_cause = 2; m_hit = first; m_ev = 1;
            end else if (m_mode == 2 && ce) begin
                m_steps = m_steps - 1;
                if (m_steps == 0) begin
                    m_mode = 0; m_cause = 3; m_ev = 1;
                end
            end
        end
        if (acc && op == SETBP && idx < NB) begin
            m_en[idx] = 1; m_addr[idx] = addr;
        end
        if (acc && op == CLRBP && idx < NB) m_en[idx] = 0;
        if (acc && op == CLRALL) begin
            for (int i = 0; i < NB; i++) m_en[i] = 0;
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [2:0] op, input int idx,
                         input logic [31:0] addr, input int cnt, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst = r; cmd_valid = v; cmd_op = op; cmd_idx = 2'(idx);
        cmd_addr = addr; cmd_cnt = 16'(cnt); pc_chk = pc;
        model_cycle(r, v, op, idx, addr, cnt, pc);
    endtask

    task automatic cmd(input logic [2:0] op, input int idx, input logic [31:0] addr,
                       input int cnt, input logic [31:0] pc);
        drive(0, 1, op, idx, addr, cnt, pc);
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(0, 0, NOP, 0, '0, 0, pc);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("cmd_ready", 32'(cmd_ready), 32'(mon_e.rdy));
            chk("cpu_ce", 32'(cpu_ce), 32'(mon_e.ce));
            chk("debug", 32'(debug), 32'(mon_e.dbg));
            chk("halt_cause", 32'(halt_cause), 32'(mon_e.cause));
            chk("hit_idx", 32'(hit_idx), 32'(mon_e.hidx));
            chk("steps_left", 32'(steps_left), 32'(mon_e.steps));
            chk("ev_halt", 32'(ev_halt), 32'(mon_e.ev));
            chk("ce_count", ce_count, mon_e.cnt);
        end
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 32'h40;
            1: return 32'h44;
            2: return 32'h48;
            3: return 32'h4C;
            default: return $urandom() & 32'hFFC;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; cmd_valid = 0; cmd_op = NOP; cmd_idx = 0; cmd_addr = 0; cmd_cnt = 0;
        pc_chk = 0;
        model_reset();
        @(posedge clk);

        // Reset, then free run for 10 cycles.
        drive(1, 0, NOP, 0, 0, 0, 0);
        cmd(RUN, 0, 0, 0, 32'h100);
        for (int i = 0; i < 10; i++) idle(32'h100 + 32'(4 * i));
        cmd(HALT, 0, 0, 0, 32'h200);
        idle(32'h200);

        // Breakpoint at 0x10 on slot 1.
        cmd(SETBP, 1, 32'h10, 0, 0);
        cmd(RUN, 0, 0, 0, 0);
        for (int i = 0; i <= 4; i++) idle(32'(4 * i));
        idle(32'h10);
        idle(32'h10);

        // Resume from the breakpointed PC: one skipped match, then halt again.
        cmd(RUN, 0, 0, 0, 32'h10);
        idle(32'h10);
        idle(32'h10);
        idle(32'h10);

        // Stepping, including the zero-count case.
        cmd(CLRALL, 0, 0, 0, 0);
        cmd(STEP, 0, 0, 3, 32'h200);
        for (int i = 0; i < 5; i++) idle(32'h204 + 32'(4 * i));
        cmd(STEP, 0, 0, 0, 32'h300);
        for (int i = 0; i < 3; i++) idle(32'h304);

        // Lowest matching index wins; clearing exposes the next.
        cmd(SETBP, 0, 32'h20, 0, 0);
        cmd(SETBP, 2, 32'h20, 0, 0);
        cmd(RUN, 0, 0, 0, 0);
        idle(32'h1C);
        idle(32'h20);
        idle(32'h20);
        cmd(CLRBP, 0, 0, 0, 32'h20);
        cmd(RUN, 0, 0, 0, 32'h20);
        idle(32'h24);
        idle(32'h20);
        idle(32'h20);
        cmd(CLRALL, 0, 0, 0, 32'h20);
        cmd(RUN, 0, 0, 0, 32'h20);
        for (int i = 0; i < 4; i++) idle(32'h20);
        cmd(HALT, 0, 0, 0, 32'h20);
        idle(32'h20);

        // Host HALT in the same cycle as a breakpoint match while stepping.
        cmd(SETBP, 0, 32'h30, 0, 0);
        cmd(STEP, 0, 0, 5, 32'h2C);
        idle(32'h2C);
        cmd(HALT, 0, 0, 0, 32'h30);
        idle(32'h30);

        // Reset in the middle of a step sequence, with a command present.
        cmd(STEP, 0, 0, 5, 32'h50);
        idle(32'h54);
        drive(1, 1, RUN, 0, 0, 0, 32'h58);
        idle(32'h58);
        idle(32'h5C);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            bit          r, v;
            logic [2:0]  op;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            drive(r, v, op, $urandom_range(0, 3), pick_addr(), $urandom_range(0, 6),
                  pick_addr());
        end

        @(negedge clk);
        #1;
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
